eth_phy_10g_rx_lock: RTL and testbench

//  10GBASE-R receive block-lock (frame sync) and BER monitor for the eth_phy_10g RX path.
//  - Checks each 66b sync header from the SERDES.
//  - Requests bitslips until block lock is reached; reports lock, high BER and link status.
//  - Sits between the SERDES gearbox output and the RX decoder, in the rx_clk domain.

---
 rtl/eth_phy_10g_pkg.sv | 21 ++
 rtl/eth_phy_10g_rx_ber_mon.sv | 39 +++
 rtl/eth_phy_10g_rx_frame_sync.sv | 103 ++++++++++
 rtl/eth_phy_10g_rx_lock.sv | 46 ++++
 tb/tb_eth_phy_10g_rx_lock.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_phy_10g_pkg.sv
// Shared definitions for the eth_phy_10g RX path: sync header codes and lock FSM states.
package eth_phy_10g_pkg;

   localparam int HDR_WIDTH = 2;

   localparam logic [HDR_WIDTH-1:0] SYNC_DATA = 2'b01;
   localparam logic [HDR_WIDTH-1:0] SYNC_CTRL = 2'b10;

   // Frame sync states: checking headers, holding bitslip high, waiting for the slip to settle
   typedef enum logic [1:0] {
      FS_CHECK   = 2'd0,
      FS_SLIP_HI = 2'd1,
      FS_SLIP_LO = 2'd2
   } fs_state_t;

   // Only 01 and 10 are legal 66b sync headers
   function automatic logic hdr_valid(input logic [HDR_WIDTH-1:0] hdr);
      return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
   endfunction

endpackage

// File: rtl/eth_phy_10g_rx_ber_mon.sv
// High-BER monitor: counts invalid sync headers per 125 us window.
module eth_phy_10g_rx_ber_mon
   import eth_phy_10g_pkg::*;
#(
   parameter int COUNT_125US = 19531
) (
   input  logic                 rx_clk,
   input  logic                 rx_rst,
   input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
   output logic                 rx_high_ber,
   output logic [3:0]           ber_count
);

   localparam int TW = $clog2(COUNT_125US + 1);
   localparam logic [TW-1:0] T_LOAD = TW'(COUNT_125US);

   logic [TW-1:0] timer;

   // Window timer and saturating error count; window rollover takes precedence over counting
   always_ff @(posedge rx_clk or posedge rx_rst) begin
      if (rx_rst) begin
         timer       <= T_LOAD;
         ber_count   <= '0;
         rx_high_ber <= 1'b0;
      end else if (timer == '0) begin
         timer     <= T_LOAD;
         ber_count <= '0;
         // A window that ended saturated keeps high BER flagged for another window
         if (ber_count != 4'd15) rx_high_ber <= 1'b0;
      end else begin
         timer <= timer - 1'b1;
         if (!hdr_valid(serdes_rx_hdr)) begin
            if (ber_count == 4'd15) rx_high_ber <= 1'b1;
            else                    ber_count   <= ber_count + 4'd1;
         end
      end
   end

endmodule

// File: rtl/eth_phy_10g_rx_frame_sync.sv
// Block lock acquisition: counts sync headers in 64-header windows and requests bitslips.
module eth_phy_10g_rx_frame_sync
   import eth_phy_10g_pkg::*;
#(
   parameter int BITSLIP_HIGH_CYCLES = 1,
   parameter int BITSLIP_LOW_CYCLES  = 8
) (
   input  logic                 rx_clk,
   input  logic                 rx_rst,
   input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
   output logic                 serdes_rx_bitslip,
   output logic                 rx_block_lock,
   output logic [5:0]           sh_count,
   output logic [3:0]           sh_invalid_count
);

   // One down-counter is shared by the high and low phases of a slip
   localparam int SLIP_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                             BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
   localparam int CW = (SLIP_MAX > 1) ? $clog2(SLIP_MAX) : 1;
   localparam logic [CW-1:0] HI_LOAD = CW'(BITSLIP_HIGH_CYCLES - 1);
   localparam logic [CW-1:0] LO_LOAD = CW'(BITSLIP_LOW_CYCLES - 1);

   fs_state_t     state, state_nxt;
   logic [CW-1:0] slip_cnt, slip_cnt_nxt;
   logic          bitslip_nxt, lock_nxt;
   logic [5:0]    sh_nxt;
   logic [3:0]    inv_nxt;

   // State and output registers; reset drops lock immediately
   always_ff @(posedge rx_clk or posedge rx_rst) begin
      if (rx_rst) begin
         state             <= FS_CHECK;
         slip_cnt          <= '0;
         serdes_rx_bitslip <= 1'b0;
         rx_block_lock     <= 1'b0;
         sh_count          <= '0;
         sh_invalid_count  <= '0;
      end else begin
         state             <= state_nxt;
         slip_cnt          <= slip_cnt_nxt;
         serdes_rx_bitslip <= bitslip_nxt;
         rx_block_lock     <= lock_nxt;
         sh_count          <= sh_nxt;
         sh_invalid_count  <= inv_nxt;
      end
   end

   // Next-state: headers are only evaluated in FS_CHECK; slip phases just count down
   always_comb begin
      state_nxt    = state;
      slip_cnt_nxt = slip_cnt;
      bitslip_nxt  = serdes_rx_bitslip;
      lock_nxt     = rx_block_lock;
      sh_nxt       = sh_count;
      inv_nxt      = sh_invalid_count;
      case (state)
         FS_SLIP_HI: begin
            if (slip_cnt != '0) begin
               slip_cnt_nxt = slip_cnt - 1'b1;
            end else begin
               bitslip_nxt  = 1'b0;
               slip_cnt_nxt = LO_LOAD;
               state_nxt    = (BITSLIP_LOW_CYCLES == 1) ? FS_CHECK : FS_SLIP_LO;
            end
         end
         FS_SLIP_LO: begin
            if (slip_cnt > 1) begin
               slip_cnt_nxt = slip_cnt - 1'b1;
            end else begin
               slip_cnt_nxt = '0;
               state_nxt    = FS_CHECK;
            end
         end
         default: begin
            sh_nxt = sh_count + 6'd1;
            if (hdr_valid(serdes_rx_hdr)) begin
               // End of a 64-header window: a clean window grants lock
               if (sh_count == 6'd63) begin
                  if (sh_invalid_count == 4'd0) lock_nxt = 1'b1;
                  sh_nxt  = '0;
                  inv_nxt = '0;
               end
            end else begin
               inv_nxt = sh_invalid_count + 4'd1;
               // Unlocked: any error slips; locked: the 16th error in a window slips
               if (!rx_block_lock || sh_invalid_count == 4'd15) begin
                  lock_nxt     = 1'b0;
                  bitslip_nxt  = 1'b1;
                  sh_nxt       = '0;
                  inv_nxt      = '0;
                  slip_cnt_nxt = HI_LOAD;
                  state_nxt    = FS_SLIP_HI;
               end else if (sh_count == 6'd63) begin
                  sh_nxt  = '0;
                  inv_nxt = '0;
               end
            end
         end
      endcase
   end

endmodule

// File: rtl/eth_phy_10g_rx_lock.sv
// 10GBASE-R RX block lock and BER monitor; sits between SERDES gearbox and RX decoder.
module eth_phy_10g_rx_lock #(
   parameter int HDR_WIDTH           = 2,  // fixed; 66b sync header
   parameter int BITSLIP_HIGH_CYCLES = 1,
   parameter int BITSLIP_LOW_CYCLES  = 8,
   parameter int COUNT_125US         = 19531
) (
   input  logic                 rx_clk,
   input  logic                 rx_rst,
   input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
   output logic                 serdes_rx_bitslip,
   output logic                 rx_block_lock,
   output logic                 rx_high_ber,
   output logic                 rx_status,
   output logic [5:0]           sh_count,
   output logic [3:0]           sh_invalid_count,
   output logic [3:0]           ber_count
);

   eth_phy_10g_rx_frame_sync #(
      .BITSLIP_HIGH_CYCLES (BITSLIP_HIGH_CYCLES),
      .BITSLIP_LOW_CYCLES  (BITSLIP_LOW_CYCLES)
   ) u_frame_sync (
      .rx_clk            (rx_clk),
      .rx_rst            (rx_rst),
      .serdes_rx_hdr     (serdes_rx_hdr),
      .serdes_rx_bitslip (serdes_rx_bitslip),
      .rx_block_lock     (rx_block_lock),
      .sh_count          (sh_count),
      .sh_invalid_count  (sh_invalid_count)
   );

   eth_phy_10g_rx_ber_mon #(
      .COUNT_125US (COUNT_125US)
   ) u_ber_mon (
      .rx_clk        (rx_clk),
      .rx_rst        (rx_rst),
      .serdes_rx_hdr (serdes_rx_hdr),
      .rx_high_ber   (rx_high_ber),
      .ber_count     (ber_count)
   );

   // Link is up only when locked and not in high BER
   assign rx_status = rx_block_lock & ~rx_high_ber;

endmodule

// File: tb/tb_eth_phy_10g_rx_lock.sv
// Randomized scoreboard bench for eth_phy_10g_rx_lock.
module tb_eth_phy_10g_rx_lock;

   localparam int HI  = 1;
   localparam int LO  = 8;
   localparam int CNT = 125;

   logic       rx_clk = 1'b0;
   logic       rx_rst = 1'b1;
   logic [1:0] serdes_rx_hdr = 2'b01;
   logic       serdes_rx_bitslip, rx_block_lock, rx_high_ber, rx_status;
   logic [5:0] sh_count;
   logic [3:0] sh_invalid_count, ber_count;

   eth_phy_10g_rx_lock #(
      .HDR_WIDTH           (2),
      .BITSLIP_HIGH_CYCLES (HI),
      .BITSLIP_LOW_CYCLES  (LO),
      .COUNT_125US         (CNT)
   ) dut (
      .rx_clk            (rx_clk),
      .rx_rst            (rx_rst),
      .serdes_rx_hdr     (serdes_rx_hdr),
      .serdes_rx_bitslip (serdes_rx_bitslip),
      .rx_block_lock     (rx_block_lock),
      .rx_high_ber       (rx_high_ber),
      .rx_status         (rx_status),
      .sh_count          (sh_count),
      .sh_invalid_count  (sh_invalid_count),
      .ber_count         (ber_count)
   );

   always #10 rx_clk = ~rx_clk;

   typedef struct {
      bit slip; bit lock; bit hb; bit st;
      int sh; int inv; int ber;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   // Reference model: edge index since reset, window tallies, time of last slip
   int m_e, m_sh, m_inv, m_ber, m_slip_at;
   bit m_lock, m_hb;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_e = 0; m_sh = 0; m_inv = 0; m_ber = 0; m_slip_at = -1000;
      m_lock = 0; m_hb = 0;
   endtask

   // Apply the lock/BER rules for one header and queue the outputs expected after the edge
   task automatic model_step(input logic [1:0] h);
      exp_t x;
      bit   v;
      m_e++;
      v = (h == 2'b01) || (h == 2'b10);
      if (m_e >= m_slip_at + HI + LO) begin
         m_sh++;
         if (v) begin
            if (m_sh == 64) begin
               if (m_inv == 0) m_lock = 1;
               m_sh = 0; m_inv = 0;
            end
         end else begin
            m_inv++;
            if (!m_lock || m_inv == 16) begin
               m_lock = 0; m_slip_at = m_e; m_sh = 0; m_inv = 0;
            end else if (m_sh == 64) begin
               m_sh = 0; m_inv = 0;
            end
         end
      end
      if (m_e % (CNT + 1) == 0) begin
         if (m_ber < 15) m_hb = 0;
         m_ber = 0;
      end else if (!v) begin
         if (m_ber == 15) m_hb = 1;
         else             m_ber++;
      end
      x.slip = (m_e >= m_slip_at) && (m_e < m_slip_at + HI);
      x.lock = m_lock;
      x.hb   = m_hb;
      x.st   = m_lock && !m_hb;
      x.sh   = m_sh;
      x.inv  = m_inv;
      x.ber  = m_ber;
      q.push_back(x);
   endtask

   // Called at a falling edge; returns at the next falling edge with the result visible
   task automatic drive(input logic [1:0] h);
      serdes_rx_hdr = h;
      model_step(h);
      @(negedge rx_clk);
   endtask

   function automatic logic [1:0] rnd_valid();
      return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [1:0] rnd_invalid();
      return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
   endfunction

   function automatic logic [1:0] rnd_hdr(input int pct_bad);
      return ($urandom_range(0, 99) < pct_bad) ? rnd_invalid() : rnd_valid();
   endfunction

   task automatic do_reset();
      @(negedge rx_clk);
      rx_rst = 1'b1;
      @(negedge rx_clk);
      rx_rst = 1'b0;
      model_reset();
   endtask

   // Monitor: every edge with a pending expectation is compared field by field
   initial begin
      exp_t x;
      forever begin
         @(posedge rx_clk);
         #1;
         if (q.size() > 0) begin
            x = q.pop_front();
            check("bitslip",     serdes_rx_bitslip, x.slip);
            check("block_lock",  rx_block_lock,     x.lock);
            check("high_ber",    rx_high_ber,       x.hb);
            check("status",      rx_status,         x.st);
            check("sh_count",    sh_count,          x.sh);
            check("sh_inv_cnt",  sh_invalid_count,  x.inv);
            check("ber_count",   ber_count,         x.ber);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) @(negedge rx_clk);
      check("rst_bitslip", serdes_rx_bitslip, 0);
      check("rst_lock",    rx_block_lock,     0);
      check("rst_high_ber", rx_high_ber,      0);
      check("rst_status",  rx_status,         0);
      check("rst_sh",      sh_count,          0);
      check("rst_inv",     sh_invalid_count,  0);
      check("rst_ber",     ber_count,         0);
      rx_rst = 1'b0;

      // 64 clean headers lock on the 64th
      repeat (63) drive(2'b01);
      check("no_lock_at_63", rx_block_lock, 0);
      drive(2'b01);
      check("lock_at_64", rx_block_lock, 1);
      check("lock_sh0",   sh_count, 0);
      check("lock_inv0",  sh_invalid_count, 0);

      // One error per window keeps lock
      repeat (4) begin
         drive(2'b00);
         check("inv_peak1", sh_invalid_count, 1);
         repeat (63) drive(rnd_valid());
      end
      check("lock_1err_windows", rx_block_lock, 1);

      // 15 errors in a window is still tolerated
      repeat (15) drive(rnd_invalid());
      repeat (49) drive(2'b01);
      check("lock_15err", rx_block_lock, 1);

      // The 16th error drops lock and slips
      repeat (15) drive(2'b00);
      check("lock_before_16th", rx_block_lock, 1);
      drive(2'b00);
      check("unlock_16th", rx_block_lock, 0);
      check("slip_16th",   serdes_rx_bitslip, 1);
      drive(2'b01);
      check("slip_1cycle", serdes_rx_bitslip, 0);
      repeat (7) drive(2'b00);
      check("ignored_sh",  sh_count, 0);

      // Unlocked: one error after 63 clean restarts acquisition
      repeat (63) drive(2'b01);
      check("sh_63", sh_count, 63);
      drive(2'b00);
      check("acq_no_lock", rx_block_lock, 0);
      check("acq_slip",    serdes_rx_bitslip, 1);
      check("acq_sh0",     sh_count, 0);

      // Relock, then asynchronous reset drops lock between edges
      repeat (8) drive(2'b01);
      repeat (64) drive(rnd_valid());
      check("relock", rx_block_lock, 1);
      rx_rst = 1'b1;
      #1;
      check("async_rst_lock",   rx_block_lock, 0);
      check("async_rst_status", rx_status, 0);
      @(negedge rx_clk);
      rx_rst = 1'b0;
      model_reset();

      // High BER: 16 errors in one window; flag survives a saturated window rollover
      repeat (16) drive(rnd_invalid());
      check("high_ber_set",   rx_high_ber, 1);
      check("high_ber_stat0", rx_status, 0);
      repeat (130 - 16) drive(2'b01);
      check("high_ber_held",  rx_high_ber, 1);
      repeat (256 - 130) drive(2'b01);
      check("high_ber_clear", rx_high_ber, 0);

      // Random headers with 1% errors lock within 500 cycles (10000 time units)
      do_reset();
      for (int i = 0; i < 500 && !rx_block_lock; i++) drive(rnd_hdr(1));
      check("rand_lock_10000", rx_block_lock, 1);

      // Mixed random traffic, including bursts, against the model
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 199) == 0) repeat ($urandom_range(1, 20)) drive(rnd_invalid());
         else drive(rnd_hdr((i / 500) * 2));
      end

      @(posedge rx_clk);
      #2;
      check("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
